// File: rtl/morse_pkg.sv
// Shared types and Morse timing thresholds for the Morse key receiver.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_e;

   localparam int unsigned UNIT_W           = 3;
   localparam int unsigned ELEM_W           = 3;
   localparam int unsigned DOT_DASH_UNITS   = 2;
   localparam int unsigned LETTER_GAP_UNITS = 3;
   localparam int unsigned MAX_MARK_UNITS   = 7;
   localparam int unsigned MAX_ELEMENTS     = 5;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and debouncer for the key input, with edge pulses
// that are aligned with the debounced level change.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Count consecutive samples that disagree with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/morse_rx.sv
// Morse key receiver: times debounced marks and spaces in units and emits
// each decoded character as a length plus dot/dash bit pattern.
module morse_rx
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES     = 2097152,
   parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   output logic       SYM_VALID,
   output logic [2:0] SYM_LEN,
   output logic [4:0] SYM_BITS,
   output logic       ERR,
   output logic       LED
);

   localparam int unsigned PW = $clog2(UNIT_CYCLES + 1);

   logic              level, rise, fall;
   logic              edge_c, tick_c;
   logic [PW-1:0]     presc_q, presc_d;
   logic [UNIT_W-1:0] units_q, units_d;
   state_e            state_q, state_d;
   logic [4:0]        acc_bits_q, acc_bits_d;
   logic [ELEM_W-1:0] acc_cnt_q, acc_cnt_d;
   logic              drop_q, drop_d;
   logic              sym_valid_q, sym_valid_d;
   logic [2:0]        sym_len_q, sym_len_d;
   logic [4:0]        sym_bits_q, sym_bits_d;
   logic              err_q, err_d;
   logic              led_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLK     (CLK),
      .RST     (RST),
      .raw_i   (BTN),
      .level_o (level),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // An edge restarts unit timing and swallows a coincident tick.
   assign edge_c = rise | fall;
   assign tick_c = (presc_q == PW'(UNIT_CYCLES - 1)) && !edge_c;

   always_comb begin
      presc_d = presc_q + PW'(1);
      units_d = units_q;
      if (edge_c) begin
         presc_d = '0;
         units_d = '0;
      end else if (tick_c) begin
         presc_d = '0;
         if (units_q != UNIT_W'(MAX_MARK_UNITS)) units_d = units_q + UNIT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (rise) state_d = ST_MARK;
         ST_MARK: begin
            // An overlong mark has no following space worth timing.
            if (fall) state_d = (units_q == UNIT_W'(MAX_MARK_UNITS)) ? ST_IDLE : ST_SPACE;
         end
         ST_SPACE: begin
            if (rise) state_d = ST_MARK;
            else if (tick_c && units_q == UNIT_W'(LETTER_GAP_UNITS - 1)) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      acc_bits_d  = acc_bits_q;
      acc_cnt_d   = acc_cnt_q;
      drop_d      = drop_q;
      sym_valid_d = 1'b0;
      sym_len_d   = sym_len_q;
      sym_bits_d  = sym_bits_q;
      err_d       = 1'b0;
      case (state_q)
         ST_MARK: begin
            if (fall) begin
               if (units_q == UNIT_W'(MAX_MARK_UNITS)) begin
                  acc_bits_d = '0;
                  acc_cnt_d  = '0;
                  drop_d     = 1'b0;
               end else if (!drop_q) begin
                  if (acc_cnt_q == ELEM_W'(MAX_ELEMENTS)) begin
                     err_d      = 1'b1;
                     acc_bits_d = '0;
                     acc_cnt_d  = '0;
                     drop_d     = 1'b1;
                  end else begin
                     acc_bits_d[acc_cnt_q] = (units_q >= UNIT_W'(DOT_DASH_UNITS));
                     acc_cnt_d             = acc_cnt_q + ELEM_W'(1);
                  end
               end
            end else if (tick_c && units_q == UNIT_W'(MAX_MARK_UNITS - 1)) begin
               err_d = 1'b1;
            end
         end
         ST_SPACE: begin
            if (tick_c && units_q == UNIT_W'(LETTER_GAP_UNITS - 1)) begin
               if (!drop_q && acc_cnt_q != '0) begin
                  sym_valid_d = 1'b1;
                  sym_len_d   = acc_cnt_q;
                  sym_bits_d  = acc_bits_q;
               end
               acc_bits_d = '0;
               acc_cnt_d  = '0;
               drop_d     = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc_q     <= '0;
         units_q     <= '0;
         acc_bits_q  <= '0;
         acc_cnt_q   <= '0;
         drop_q      <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_len_q   <= '0;
         sym_bits_q  <= '0;
         err_q       <= 1'b0;
         led_q       <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         units_q     <= units_d;
         acc_bits_q  <= acc_bits_d;
         acc_cnt_q   <= acc_cnt_d;
         drop_q      <= drop_d;
         sym_valid_q <= sym_valid_d;
         sym_len_q   <= sym_len_d;
         sym_bits_q  <= sym_bits_d;
         err_q       <= err_d;
         led_q       <= level;
      end
   end

   assign SYM_VALID = sym_valid_q;
   assign SYM_LEN   = sym_len_q;
   assign SYM_BITS  = sym_bits_q;
   assign ERR       = err_q;
   assign LED       = led_q;

endmodule

// File: tb/tb_morse_rx.sv
// Scoreboard bench for morse_rx: characters are keyed with jittered timing
// and the expected decode events are queued for a free-running monitor.
module tb_morse_rx;

   localparam int unsigned UNIT = 8;
   localparam int unsigned DEB  = 2;

   logic       CLK, RST, BTN;
   logic       SYM_VALID, ERR, LED;
   logic [2:0] SYM_LEN;
   logic [4:0] SYM_BITS;

   typedef struct {
      bit         is_err;
      logic [2:0] len;
      logic [4:0] bits;
   } ev_t;

   ev_t        exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [2:0] last_len  = '0;
   logic [4:0] last_bits = '0;

   morse_rx #(.UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(DEB)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .BTN       (BTN),
      .SYM_VALID (SYM_VALID),
      .SYM_LEN   (SYM_LEN),
      .SYM_BITS  (SYM_BITS),
      .ERR       (ERR),
      .LED       (LED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (!RST && (SYM_VALID || ERR)) begin
         if (SYM_VALID && ERR) check("valid_and_err_together", 1, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_kind_err", int'(ERR), int'(e.is_err));
            if (!e.is_err) begin
               check("sym_len", int'(SYM_LEN), int'(e.len));
               check("sym_bits", int'(SYM_BITS), int'(e.bits));
            end
         end
      end
   end

   task automatic drive(input logic v, input int n);
      BTN = v;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic mark(input int n);
      drive(1'b1, n);
      if (n >= 8) check("led_during_mark", int'(LED), 1);
   endtask

   task automatic letter_gap(input bit glitch);
      if (glitch) begin
         drive(1'b0, 10);
         drive(1'b1, 1);
         drive(1'b0, 34);
      end else begin
         drive(1'b0, 45);
      end
      check("led_in_gap", int'(LED), 0);
      check("hold_len", int'(SYM_LEN), int'(last_len));
      check("hold_bits", int'(SYM_BITS), int'(last_bits));
   endtask

   // Element i of pat (bit0 first) is a dash when set.
   task automatic send_char(input int n, input logic [5:0] pat, input bit glitch);
      ev_t e;
      e.is_err = (n > 5);
      e.len    = (n > 5) ? 3'd0 : 3'(n);
      e.bits   = '0;
      for (int i = 0; i < n && i < 5; i++) e.bits[i] = pat[i];
      if (n > 5) e.bits = '0;
      exp_q.push_back(e);
      if (!e.is_err) begin
         last_len  = e.len;
         last_bits = e.bits;
      end
      for (int i = 0; i < n; i++) begin
         mark(pat[i] ? int'($urandom_range(20, 30)) : int'($urandom_range(4, 12)));
         if (i < n - 1) begin
            if (glitch) begin
               drive(1'b0, 5);
               drive(1'b1, 1);
               drive(1'b0, int'($urandom_range(5, 8)));
            end else begin
               drive(1'b0, int'($urandom_range(6, 14)));
            end
         end
      end
      letter_gap(glitch);
   endtask

   task automatic check_reset_outputs();
      check("rst_sym_valid", int'(SYM_VALID), 0);
      check("rst_err", int'(ERR), 0);
      check("rst_sym_len", int'(SYM_LEN), 0);
      check("rst_sym_bits", int'(SYM_BITS), 0);
      check("rst_led", int'(LED), 0);
   endtask

   initial begin
      ev_t e;
      RST = 1'b1;
      BTN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs();
      RST = 1'b0;
      drive(1'b0, 5);

      send_char(3, 6'b000010, 1'b0);   // R
      send_char(5, 6'b011111, 1'b0);   // 0
      send_char(6, 6'b111111, 1'b0);   // six elements: error only

      // Overlong mark: error, then silence, then E.
      e.is_err = 1'b1; e.len = '0; e.bits = '0;
      exp_q.push_back(e);
      mark(64);
      letter_gap(1'b0);
      send_char(1, 6'b000000, 1'b0);   // E

      send_char(3, 6'b000101, 1'b1);   // K with glitches in spaces

      // Reset mid-character with the key held through reset release.
      mark(8);
      drive(1'b0, 10);
      mark(24);
      drive(1'b0, 10);
      BTN = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs();
      last_len  = '0;
      last_bits = '0;
      e.is_err = 1'b0; e.len = 3'd1; e.bits = 5'b00001;
      exp_q.push_back(e);
      last_len  = 3'd1;
      last_bits = 5'b00001;
      RST = 1'b0;
      mark(26);
      letter_gap(1'b0);                // T

      for (int k = 0; k < 20; k++) begin
         send_char(int'($urandom_range(1, 5)), 6'($urandom), bit'($urandom_range(0, 1)));
      end

      drive(1'b0, 20);
      check("events_outstanding", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/morse_rx.md
MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 2097152 (2^21, 131 ms at 16 MHz), CLK cycles per Morse time unit.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16000 (1 ms), cycles the synchronised input must be stable before it is accepted.
REQ-003 The block SHALL have port CLK  input  1  16 MHz clock; the only clock.
REQ-004 The block SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port BTN  input  1  asynchronous key/button pin; 1 = key down (mark).
REQ-006 The block SHALL have port SYM_VALID  output  1  one-cycle pulse when a decoded character is presented.
REQ-007 The block SHALL have port SYM_LEN  output  3  element count 1..5 of the presented character.
REQ-008 The block SHALL have port SYM_BITS  output  5  elements, bit0 = first; 1 = dash, 0 = dot; unused bits 0.
REQ-009 The block SHALL have port ERR  output  1  one-cycle pulse on overlong mark or >5 elements.
REQ-010 The block SHALL have port LED  output  1  debounced key level echo.

Function
REQ-011 BTN SHALL pass a 2-flop synchroniser, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-012 A unit prescaler SHALL count 0..UNIT_CYCLES-1 and emit a unit tick on wrap; it restarts at 0 on every debounced edge.
REQ-013 A unit counter SHALL count ticks since the last debounced edge, saturating at 7 (3 bits).
REQ-014 FSM states SHALL be IDLE, MARK, SPACE; IDLE->MARK on rising edge; MARK->SPACE on falling edge; SPACE->MARK on rising edge.
REQ-015 On MARK->SPACE the element SHALL be classified: units <2 -> dot, units >=2 -> dash, stored at bit index = current element count; count increments.
REQ-016 In MARK, reaching 7 units SHALL pulse ERR, discard the character, and enter IDLE only after the key is released (no element recorded).
REQ-017 In SPACE, units reaching 3 (letter gap) SHALL assert SYM_VALID for exactly one cycle with SYM_LEN/SYM_BITS of the accumulated character, then clear the accumulator and enter IDLE.
REQ-018 A 6th classified element SHALL pulse ERR, clear the accumulator; the character is not emitted; the letter gap then returns to IDLE silently.
REQ-019 Latency: SYM_VALID SHALL occur the cycle after the unit tick that makes the gap count 3.
REQ-020 SYM_LEN/SYM_BITS SHALL hold their last presented value between pulses; SYM_VALID and ERR never assert in the same cycle.
REQ-021 A debounced edge coinciding with a unit tick SHALL take priority: the edge is processed, the tick is dropped.
REQ-022 Debounce glitches shorter than DEBOUNCE_CYCLES SHALL produce no state change and no output.
REQ-023 LED SHALL equal the debounced level, one cycle after it updates.

Reset
REQ-024 While RST=1 at a CLK edge: FSM=IDLE, all counters/synchroniser/debouncer = 0, debounced level = 0, SYM_VALID=0, ERR=0, SYM_LEN=0, SYM_BITS=0, LED=0.
REQ-025 RST mid-character SHALL discard the partial character with no SYM_VALID or ERR pulse; a key held through reset release is seen as a new rising edge after debounce.

Structure
REQ-026 Package morse_pkg SHALL hold the FSM state enum, DOT_DASH_UNITS=2, LETTER_GAP_UNITS=3, MAX_MARK_UNITS=7, MAX_ELEMENTS=5.
REQ-027 Synchroniser plus debouncer SHALL be one sub-module, btn_debounce (ports CLK, RST, raw in, level out, rise/fall pulses).

Verification (UNIT_CYCLES=8, DEBOUNCE_CYCLES=2)
REQ-028 Marks of 1,3,1 units with 1-unit gaps, then 3-unit gap -> one SYM_VALID, SYM_LEN=3, SYM_BITS=00010 ("R").
REQ-029 Five 3-unit marks then 3-unit gap -> SYM_LEN=5, SYM_BITS=11111 ("0"); a sixth mark instead -> ERR pulse, no SYM_VALID.
REQ-030 Mark held 8 units -> ERR pulse at unit 7, no SYM_VALID after release and gap; next "E" (1-unit mark) decodes SYM_LEN=1, SYM_BITS=00000.
REQ-031 1-cycle BTN glitches during SPACE -> no edge, character still emitted at 3-unit gap.
REQ-032 RST asserted in MARK after two elements -> all outputs 0, no pulses; subsequent "T" (3-unit mark) decodes SYM_LEN=1, SYM_BITS=00001.
